// File: rtl/bp_table_sched_pkg.sv
// Shared sizes, state encodings and update-bundle width for the branch-predictor
// table write scheduler.
package bp_table_sched_pkg;

  localparam int BP_SWEEP_N = 32;
  localparam int BP_IDX_W   = 5;
  localparam int BP_Q_DEPTH = 4;
  localparam int BP_DROP_W  = 8;

  // Update bundle layout: {direct, indirect, taken, pc[31:0], target[31:0]}
  localparam int BP_UPD_BUS_W = 67;

  typedef enum logic {
    BP_ST_SWEEP = 1'b0,
    BP_ST_RUN   = 1'b1
  } bp_state_e;

endpackage

// File: rtl/bp_table_sched_upd_fifo.sv
// In-order update FIFO (module bp_upd_fifo) with a count field for full/empty and a
// synchronous flush.
module bp_upd_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_table_sched.sv
// Branch-predictor table write scheduler: zeroing sweep after reset/clear, then one
// retired-branch update write per cycle, buffered through a small FIFO.
module bp_table_sched
  import bp_table_sched_pkg::*;
#(
  parameter int SWEEP_N = BP_SWEEP_N,
  parameter int IDX_W   = BP_IDX_W,
  parameter int Q_DEPTH = BP_Q_DEPTH,
  parameter int DROP_W  = BP_DROP_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_req,
  input  logic              upd_valid,
  input  logic              upd_direct,
  input  logic              upd_indirect,
  input  logic              upd_taken,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  output logic              clr_we,
  output logic [IDX_W-1:0]  clr_idx,
  output logic              wr_we,
  output logic              wr_direct,
  output logic              wr_indirect,
  output logic              wr_taken,
  output logic [31:0]       wr_pc,
  output logic [31:0]       wr_target,
  output logic              pred_en,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              dbg_state
);

  bp_state_e                state;
  logic [IDX_W-1:0]         cnt;
  logic [BP_UPD_BUS_W-1:0]  upd_bus;
  logic [BP_UPD_BUS_W-1:0]  head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     relevant;
  logic                     pop;
  logic                     bypass;
  logic                     push;
  logic                     drop;

  // Updates touching no table are invisible; clr_req swallows the cycle's update.
  assign relevant = upd_valid & (upd_direct | upd_indirect) & ~clr_req;
  assign pop      = (state == BP_ST_RUN) & ~fifo_empty & ~clr_req;
  assign bypass   = (state == BP_ST_RUN) & fifo_empty & relevant;
  assign push     = relevant & ~bypass & (~fifo_full | pop);
  assign drop     = relevant & ~bypass & fifo_full & ~pop;
  assign upd_bus  = {upd_direct, upd_indirect, upd_taken, upd_pc, upd_target};
  assign dbg_state = state;

  bp_upd_fifo #(
    .WIDTH (BP_UPD_BUS_W),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (clr_req),
    .din   (upd_bus),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= BP_ST_SWEEP;
      cnt         <= '0;
      clr_we      <= 1'b0;
      clr_idx     <= '0;
      wr_we       <= 1'b0;
      wr_direct   <= 1'b0;
      wr_indirect <= 1'b0;
      wr_taken    <= 1'b0;
      wr_pc       <= '0;
      wr_target   <= '0;
      pred_en     <= 1'b0;
      busy        <= 1'b1;
    end else if (clr_req) begin
      state   <= BP_ST_SWEEP;
      cnt     <= '0;
      clr_we  <= 1'b0;
      wr_we   <= 1'b0;
      pred_en <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        BP_ST_SWEEP: begin
          clr_we  <= 1'b1;
          clr_idx <= cnt;
          wr_we   <= 1'b0;
          if (cnt == IDX_W'(SWEEP_N - 1)) begin
            cnt   <= '0;
            state <= BP_ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BP_ST_RUN: begin
          // pred_en rises only once the last clear write has retired.
          clr_we  <= 1'b0;
          pred_en <= 1'b1;
          busy    <= 1'b0;
          wr_we   <= pop | bypass;
          if (pop) begin
            {wr_direct, wr_indirect, wr_taken, wr_pc, wr_target} <= head;
          end else if (bypass) begin
            {wr_direct, wr_indirect, wr_taken, wr_pc, wr_target} <= upd_bus;
          end
        end
        default: state <= BP_ST_SWEEP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       drop_cnt <= '0;
    else if (drop && ~&drop_cnt)     drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: doc/bp_table_sched.md
Name: bp_table_sched

Overview:
- Scheduler for the branch-predictor tables: BTB valid bits, BHT, PHT and target cache.
- Owns the table write port. After reset, and on a clear request, it runs a zeroing sweep over every table index.
- Accepts retired-branch updates from the writeback stage and issues at most one table write per cycle; updates are buffered in a small FIFO while a sweep runs.
- Gates prediction (pred_en) until the tables are known-clean.
- Sits between writeback (update source) and the pre-decode predictor tables (write sink).

Parameters:
- SWEEP_N, 32: number of indexes cleared per sweep; covers the largest table (2**BHR_Wid).
- IDX_W, 5: clog2(SWEEP_N); width of the clear index.
- Q_DEPTH, 4: update FIFO depth; power of two, at least 2.
- DROP_W, 8: width of the drop counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- clr_req  in  1  request a full table clear (e.g. predictor context flush); one-cycle pulse
- upd_valid  in  1  retired branch update present this cycle
- upd_direct  in  1  update targets the BTB (jirl/b/bl)
- upd_indirect  in  1  update targets the BHT/PHT (conditional branch)
- upd_taken  in  1  resolved direction
- upd_pc  in  32  branch PC
- upd_target  in  32  resolved target
- clr_we  out  1  clear-write strobe: all tables write zero at clr_idx
- clr_idx  out  IDX_W  index being cleared
- wr_we  out  1  update-write strobe
- wr_direct, wr_indirect, wr_taken  out  1 each  registered copies of the issued update
- wr_pc, wr_target  out  32 each  registered copies of the issued update
- pred_en  out  1  predictor outputs may be used; low forces predict-not-taken
- busy  out  1  a sweep is in progress
- drop_cnt  out  DROP_W  updates discarded because the FIFO was full; saturating

Behaviour:
- States: SWEEP, RUN. Encodings live in the shared header.
- Reset (async, rstn=0) values:
  - state=SWEEP, sweep counter=0, FIFO empty, drop_cnt=0.
  - All wr_* outputs 0, clr_we=0, pred_en=0, busy=1.
- SWEEP:
  - Every cycle, registered: clr_we=1, clr_idx=counter, counter+1.
  - After the cycle that issues clr_idx=SWEEP_N-1, go to RUN. clr_we=0 from then on.
  - One full sweep takes exactly SWEEP_N cycles of clr_we after reset deassertion.
  - wr_we is never asserted in SWEEP; clear and update writes never coincide.
- RUN:
  - pred_en=1 and busy=0 from the first RUN cycle.
  - FIFO non-empty: pop the head into the wr_* registers; wr_we=1 the next cycle.
  - FIFO empty and upd_valid=1: bypass the update straight into the wr_* registers; wr_we=1 next cycle (latency 1).
  - Otherwise wr_we=0.
- Update acceptance (any state):
  - Enqueue when upd_valid=1 and the update does not take the bypass path.
  - A full FIFO with a simultaneous pop accepts the push (the slot is freed).
  - A full FIFO with no pop drops the update; drop_cnt increments and saturates at all-ones.
  - Updates with upd_direct=0 and upd_indirect=0 are ignored: not queued, not counted.
- FIFO ordering: strict in-order. Pointers wrap modulo Q_DEPTH. A count field distinguishes full from empty.
- clr_req:
  - Highest priority. Next cycle: state=SWEEP, counter=0, FIFO flushed, pred_en=0.
  - A simultaneous upd_valid is discarded and not counted as a drop.
  - clr_req during SWEEP restarts the counter at 0.
  - A wr_we already registered for this cycle still completes. Its row is re-cleared by the new sweep.
- Clear-index limit: clr_idx never exceeds SWEEP_N-1. Counter wrap is unreachable by construction.
- Table semantics are applied by the consumer, not by this block:
  - wr_direct: BTB write.
  - wr_indirect: BHT shift plus PHT update.
  - wr_indirect & wr_taken: TC write.

Decomposition:
- Defines.vh: BP_SWEEP_N, BP_Q_DEPTH and the state encodings BP_ST_SWEEP/BP_ST_RUN, plus a BP_UPD_BUS_Wid macro for the 67-bit update bundle {direct, indirect, taken, pc, target}.
- One sub-module, bp_upd_fifo:
  - Parameterised width/depth, async active-low reset.
  - Ports: push, pop, din, dout, full, empty, flush.
  - Instantiated once.

Test Plan:
- Release rstn; hold upd_valid=0 -> clr_we=1 for exactly 32 consecutive cycles with clr_idx 0..31; then pred_en=1, busy=0.
- In RUN with FIFO empty, upd_valid=1, indirect=1, taken=1, pc=0x1c000100, target=0x1c000200 -> one cycle later wr_we=1 with identical fields; wr_we=0 the cycle after.
- During SWEEP, push 6 direct updates back-to-back -> first 4 queued, drop_cnt=2; after the sweep, wr_we=1 for 4 consecutive cycles with PCs in push order.
- In RUN, pulse clr_req together with upd_valid while the FIFO holds 3 entries -> the incoming update is discarded, FIFO empty, drop_cnt unchanged, new 32-cycle sweep, pred_en=0 throughout.
- Assert rstn=0 mid-sweep at clr_idx=17 -> all outputs reset immediately without waiting for a clock edge; after release the sweep restarts at clr_idx=0.
- Force 300 drops (FIFO full, no RUN) -> drop_cnt saturates at 255.
